// File: rtl/gate_sweeper.sv
// Exhaustive 16-vector tester for a 4-input gate network: drives {a,b,c,d} = 0..15,
// captures the network's x/y responses and counts vectors that differ from the golden function.
module gate_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        x_in,
  input  logic        y_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [15:0] x_tab,
  output logic [15:0] y_tab,
  output logic [4:0]  err_count,
  output logic        mismatch,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // Golden response {ex, ey} for vector v, where v = {a,b,c,d}.
  function automatic logic [1:0] golden(input logic [3:0] v);
    logic ga, gb, gc, gd;
    ga = v[3];
    gb = v[2];
    gc = v[1];
    gd = v[0];
    golden = {(~((ga & gb) | gc)) | (gc & gd), gc & gd};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] x_tab_q, x_tab_d;
  logic [15:0] y_tab_q, y_tab_d;
  logic [4:0]  err_q, err_d;
  logic        mismatch_q, mismatch_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  gold_s;
  logic        miss_s;

  // Next-state, capture and scoring logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    x_tab_d    = x_tab_q;
    y_tab_d    = y_tab_q;
    err_d      = err_q;
    mismatch_d = mismatch_q;
    gold_s     = golden(idx_q);
    miss_s     = (x_in != gold_s[1]) || (y_in != gold_s[0]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_DRIVE;
          idx_d      = 4'd0;
          cnt_d      = 4'd0;
          x_tab_d    = 16'd0;
          y_tab_d    = 16'd0;
          err_d      = 5'd0;
          mismatch_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        // An abort on the sample edge wins: nothing is captured for this vector.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          x_tab_d[idx_q] = x_in;
          y_tab_d[idx_q] = y_in;
          if (miss_s && (err_q != 5'd16)) begin
            err_d      = err_q + 5'd1;
            mismatch_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRIVE;
            idx_d   = idx_q + 4'd1;
            cnt_d   = 4'd0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output registers follow the next state so they line up with the state flop.
  always_comb begin
    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    if (busy_d) begin
      abcd_d = idx_d;
    end else begin
      abcd_d = 4'd0;
    end
  end

  // State and output flops, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      cnt_q      <= 4'd0;
      x_tab_q    <= 16'd0;
      y_tab_q    <= 16'd0;
      err_q      <= 5'd0;
      mismatch_q <= 1'b0;
      abcd_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      x_tab_q    <= x_tab_d;
      y_tab_q    <= y_tab_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      abcd_q     <= abcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign a         = abcd_q[3];
  assign b         = abcd_q[2];
  assign c         = abcd_q[1];
  assign d         = abcd_q[0];
  assign x_tab     = x_tab_q;
  assign y_tab     = y_tab_q;
  assign err_count = err_q;
  assign mismatch  = mismatch_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
